// File: rtl/x_wave_player_pkg.sv
// x_wave_player_pkg
// Shared constants and the sequencer state type for the wave player.
//   AW   : sample memory address width (2048 entries)
//   DW   : sample width
//   DIVW : rate divider width
package x_wave_player_pkg;

  localparam int AW   = 11;
  localparam int DW   = 2;
  localparam int DIVW = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

endpackage

// File: rtl/x_wave_player_div.sv
// x_wave_player_div
// Loadable down-counter that sets how long each sample is held.
//   i_clk      : clock
//   i_nrst     : asynchronous active-low reset
//   i_load     : load i_load_val (takes priority over decrement)
//   i_load_val : value to load
//   i_dec      : decrement by one, saturating at zero
//   o_zero     : counter currently reads zero
module x_wave_player_div
  import x_wave_player_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_load,
  input  logic [DIVW-1:0] i_load_val,
  input  logic            i_dec,
  output logic            o_zero
);

  logic [DIVW-1:0] r_count;

  // Count register: a load restarts the hold interval, otherwise count down
  // and park at zero so the zero flag stays asserted until the next load.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/x_wave_player.sv
// x_wave_player
// Owns the single address/write port of the 2048x2 sample memory. While idle
// it streams 2-bit symbols into consecutive addresses; on start it plays
// addresses 0..len back at a programmable rate, optionally looping.
//   i_clk, i_nrst              : clock, asynchronous active-low reset
//   i_ld_valid/i_ld_data       : load stream in, o_ld_ready handshake out
//   i_start/i_stop             : begin / abort playback
//   i_len/i_div/i_loop         : playback settings, captured at start
//   o_mem_addr/we/wdata        : memory port; i_mem_rdata is read data
//   o_sample/o_sample_vld      : sample to the DAC stage and update strobe
//   o_busy/o_done              : playing / natural end of a one-shot play
module x_wave_player
  import x_wave_player_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_ld_valid,
  input  logic [DW-1:0]   i_ld_data,
  output logic            o_ld_ready,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic [AW-1:0]   i_len,
  input  logic [DIVW-1:0] i_div,
  input  logic            i_loop,
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_mem_we,
  output logic [DW-1:0]   o_mem_wdata,
  input  logic [DW-1:0]   i_mem_rdata,
  output logic [DW-1:0]   o_sample,
  output logic            o_sample_vld,
  output logic            o_busy,
  output logic            o_done
);

  state_t          r_state;
  state_t          w_nextState;
  logic [AW-1:0]   r_wPtr;
  logic [AW-1:0]   r_rPtr;
  logic [AW-1:0]   r_len;
  logic [DIVW-1:0] r_div;
  logic            r_loop;
  logic            r_ldReady;
  logic            r_busy;
  logic            r_done;
  logic            r_sampleVld;
  logic [DW-1:0]   r_sample;

  logic w_write;
  logic w_startAcc;
  logic w_capture;
  logic w_holdEnd;
  logic w_lastAddr;
  logic w_divZero;

  // A stop held together with start in IDLE suppresses the start, and a stop
  // during CAPTURE or HOLD must not update the sample or advance the pointer.
  assign w_write    = i_ld_valid & r_ldReady;
  assign w_startAcc = (r_state == IDLE) & i_start & ~i_stop;
  assign w_capture  = (r_state == CAPTURE) & ~i_stop;
  assign w_holdEnd  = (r_state == HOLD) & w_divZero & ~i_stop;
  assign w_lastAddr = (r_rPtr == r_len);

  // The address follows the write pointer while idle and the read pointer
  // otherwise, so it stays stable from FETCH through CAPTURE for both
  // registered and combinational memory read models.
  assign o_mem_we    = w_write;
  assign o_mem_addr  = (r_state == IDLE) ? r_wPtr : r_rPtr;
  assign o_mem_wdata = i_ld_data;

  assign o_ld_ready   = r_ldReady;
  assign o_sample     = r_sample;
  assign o_sample_vld = r_sampleVld;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

  // Hold counter: reloaded on every capture, counted down through HOLD.
  x_wave_player_div u_div (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_load     (w_capture),
    .i_load_val (r_div),
    .i_dec      (r_state == HOLD),
    .o_zero     (w_divZero)
  );

  // Next-state logic: stop wins everywhere outside IDLE; HOLD leaves for IDLE
  // only at the end of a non-looping play, otherwise it fetches the next sample.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_startAcc) w_nextState = FETCH;
      FETCH:   w_nextState = i_stop ? IDLE : CAPTURE;
      CAPTURE: w_nextState = i_stop ? IDLE : HOLD;
      HOLD: begin
        if (i_stop) begin
          w_nextState = IDLE;
        end else if (w_divZero) begin
          w_nextState = (w_lastAddr && !r_loop) ? IDLE : FETCH;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register plus the status flags that are simply registered views of
  // where the sequencer is heading next.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state   <= IDLE;
      r_ldReady <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_ldReady <= (w_nextState == IDLE);
      r_busy    <= (w_nextState != IDLE);
      r_done    <= w_holdEnd & w_lastAddr & ~r_loop;
    end
  end

  // Pointers and captured play settings. A start clears the write pointer
  // even when a load lands in the same cycle; that write already went to the
  // old address combinationally.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wPtr <= '0;
      r_rPtr <= '0;
      r_len  <= '0;
      r_div  <= '0;
      r_loop <= 1'b0;
    end else if (w_startAcc) begin
      r_wPtr <= '0;
      r_rPtr <= '0;
      r_len  <= i_len;
      r_div  <= i_div;
      r_loop <= i_loop;
    end else begin
      if (w_write) begin
        r_wPtr <= r_wPtr + 1'b1;
      end
      if (w_holdEnd) begin
        if (!w_lastAddr) begin
          r_rPtr <= r_rPtr + 1'b1;
        end else if (r_loop) begin
          r_rPtr <= '0;
        end
      end
    end
  end

  // Sample output: latched from memory in CAPTURE and otherwise held,
  // including across stop and the natural end of play.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_sample    <= '0;
      r_sampleVld <= 1'b0;
    end else begin
      r_sampleVld <= w_capture;
      if (w_capture) begin
        r_sample <= i_mem_rdata;
      end
    end
  end

endmodule
